axicb_rd_ostd_ctrl: RTL and testbench
=====================================

Name: axicb_rd_ostd_ctrl

Overview:
Read-path admission controller placed in front of the per-master read slave switch. It tracks outstanding read requests and holds off a new AR that targets a different slave while reads are still in flight, so R completions reach the master in issue order. It also caps outstanding reads at MST_OSTDREQ_NUM and flags stalled completions with a watchdog timer.

Parameters:
- SLV_NB, 4, number of slaves. Target vector width is SLV_NB+1; bit SLV_NB is the DECERR/misroute target.
- MST_OSTDREQ_NUM, 4, maximum number of outstanding reads (≥1).
- TIMEOUT_ENABLE, 1, enables the watchdog.
- TIMEOUT_CYCLES, 1024, watchdog threshold in cycles (≥2).
- CNT_W, $clog2(MST_OSTDREQ_NUM+1), outstanding counter width (derived).

Ports:
- aclk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- srst  in  1  synchronous reset, active-high
- i_arvalid  in  1  AR valid from master
- i_arready  out  1  AR ready to master
- i_ar_tgt  in  SLV_NB+1  one-hot decoded target of the current AR; must be stable while i_arvalid=1
- o_arvalid  out  1  AR valid to switch
- o_arready  in  1  AR ready from switch
- i_rdone  in  1  pulse on the master-side R handshake with rlast (rvalid & rready & rlast)
- o_cur_tgt  out  SLV_NB+1  one-hot target currently owning the outstanding reads
- o_ostd_cnt  out  CNT_W  number of outstanding reads
- o_state  out  2  state: 0=IDLE, 1=ACTIVE, 2=DRAIN
- o_timeout  out  1  watchdog flag
- o_underflow  out  1  one-cycle pulse when i_rdone arrives while cnt=0

Behaviour:
- Reset, by either arst or srst: cnt=0, cur_tgt=0, state=IDLE, timer=0, o_timeout=0, o_underflow=0.
  - While in reset, i_arready=0 and o_arvalid=0 (they are combinational from reset state and i_arvalid).
- allow = (i_ar_tgt != 0) & (cnt < MST_OSTDREQ_NUM) & ((cnt == 0) | (i_ar_tgt == cur_tgt)).
  - allow depends only on registered state and i_ar_tgt; o_arready must not feed allow.
- AR pass-through (zero latency): o_arvalid = i_arvalid & allow; i_arready = o_arready & allow.
- ar_hs = o_arvalid & o_arready.
- Counter update, evaluated every cycle:
  - ar_hs & !i_rdone: cnt+1; cur_tgt <= i_ar_tgt.
  - i_rdone & !ar_hs: cnt-1. If cnt=0, cnt stays 0 and o_underflow pulses.
  - Both asserted: cnt unchanged; cur_tgt <= i_ar_tgt.
  - cnt never exceeds MST_OSTDREQ_NUM.
- cur_tgt holds its value when cnt returns to 0; it is only overwritten on ar_hs.
- FSM, registered:
  - IDLE: cnt=0. On ar_hs go to ACTIVE.
  - ACTIVE: cnt>0.
    - If i_arvalid with a nonzero i_ar_tgt != cur_tgt, go to DRAIN.
    - If the next cnt is 0, go to IDLE.
  - DRAIN: AR is blocked by allow.
    - When the next cnt is 0, go to IDLE.
    - If i_arvalid drops while cnt>0, return to ACTIVE.
  - The value 3 is unused; if reached, it returns to IDLE.
- i_ar_tgt=0 (no target decoded): never forwarded and held indefinitely. The upstream misroute logic must set bit SLV_NB.
- Watchdog (TIMEOUT_ENABLE=1):
  - timer clears when cnt=0 or i_rdone=1; otherwise it increments and saturates at TIMEOUT_CYCLES.
  - o_timeout=1 while timer==TIMEOUT_CYCLES.
  - o_timeout clears the cycle after i_rdone or after cnt reaches 0.
- TIMEOUT_ENABLE=0: timer logic is removed and o_timeout is tied to 0.

Decomposition:
- Shared package axicb_pkg:
  - state enum (IDLE/ACTIVE/DRAIN), 2 bits
  - helper function onehot_valid(), true when the vector has 0 or 1 bits set, used by assertions
- One sub-module, axicb_watchdog:
  - inputs: clr, run
  - output: expired
  - parameter: TIMEOUT_CYCLES
- Assertions in the RTL:
  - i_ar_tgt is one-hot whenever i_arvalid=1
  - cnt ≤ MST_OSTDREQ_NUM

Test Plan:
- Same-target burst: 5 ARs to tgt=4'b0001 with o_arready=1, no rdone → first 4 pass; the 5th is held (i_arready=0, cnt=4); one i_rdone → 5th passes the next cycle, cnt=4.
- Target switch: cnt=2 on slave0, AR to slave2 → state=DRAIN, o_arvalid=0. Two rdone pulses → IDLE, AR to slave2 forwarded, o_cur_tgt=5'b00100, cnt=1.
- Simultaneous AR handshake and rdone with cnt=3 → cnt stays 3, o_cur_tgt unchanged, state=ACTIVE.
- Underflow: i_rdone with cnt=0 → o_underflow=1 for one cycle, cnt=0, state=IDLE.
- Watchdog: TIMEOUT_CYCLES=16, one AR, no rdone → o_timeout=1 from cycle 16 after the handshake; rdone → o_timeout=0 next cycle, cnt=0.
- Reset mid-operation: cnt=3 in DRAIN, assert arst asynchronously → immediately cnt=0, state=IDLE, o_timeout=0, i_arready=0. Same check repeated with srst at the next clock edge.

Source files
------------

// File: rtl/axicb_pkg.sv
// Shared definitions for the AXI crossbar read outstanding-request controller.
//   state_t      : admission FSM encoding (IDLE/ACTIVE/DRAIN), 2 bits
//   onehot_valid : true when a vector has zero or one bit set
package axicb_pkg;

  localparam int unsigned ONEHOT_CHK_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Callers zero-extend narrower vectors into the 64-bit argument.
  function automatic logic onehot_valid(input logic [ONEHOT_CHK_W-1:0] v);
    return (v & (v - ONEHOT_CHK_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/axicb_rd_ostd_ctrl_if.sv
// AR handshake bundle around the read admission controller.
//   i_arvalid/i_arready/i_ar_tgt : master-side AR channel (tgt is one-hot decoded)
//   o_arvalid/o_arready          : switch-side AR channel
//   i_rdone                      : master-side R handshake with rlast
// Modports: slave = controller side, master = environment driving it.
interface axicb_rd_ostd_ctrl_if #(
  parameter int unsigned SLV_NB = 4
) ();

  logic              i_arvalid;
  logic              i_arready;
  logic [SLV_NB:0]   i_ar_tgt;
  logic              o_arvalid;
  logic              o_arready;
  logic              i_rdone;

  modport slave (
    input  i_arvalid,
    input  i_ar_tgt,
    input  o_arready,
    input  i_rdone,
    output i_arready,
    output o_arvalid
  );

  modport master (
    output i_arvalid,
    output i_ar_tgt,
    output o_arready,
    output i_rdone,
    input  i_arready,
    input  o_arvalid
  );

endinterface

// File: rtl/axicb_watchdog.sv
// Saturating stall timer.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (highest priority)
//   run      : count enable
//   expired  : high while the timer sits at TIMEOUT_CYCLES
module axicb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] r_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (clr) begin
      r_timer <= '0;
    end else if (run && (r_timer != TMR_MAX)) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign expired = (r_timer == TMR_MAX);

endmodule

// File: rtl/axicb_rd_ostd_ctrl.sv
// Read-path admission controller in front of the per-master read switch.
// Tracks outstanding reads, blocks a new AR to a different slave until all
// reads in flight have completed (keeps R in issue order), caps outstanding
// reads at MST_OSTDREQ_NUM and flags stalled completions with a watchdog.
//   aclk, arst, srst : clock, async reset, sync reset (both active-high)
//   bus              : AR handshake bundle (slave modport)
//   o_cur_tgt        : one-hot target owning the outstanding reads
//   o_ostd_cnt       : outstanding read count
//   o_state          : 0=IDLE 1=ACTIVE 2=DRAIN
//   o_timeout        : watchdog flag
//   o_underflow      : one-cycle pulse, completion seen with nothing outstanding
module axicb_rd_ostd_ctrl
  import axicb_pkg::*;
#(
  parameter int unsigned SLV_NB          = 4,
  parameter int unsigned MST_OSTDREQ_NUM = 4,
  parameter bit          TIMEOUT_ENABLE  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned CNT_W           = $clog2(MST_OSTDREQ_NUM + 1)
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  srst,
  axicb_rd_ostd_ctrl_if.slave   bus,
  output logic [SLV_NB:0]       o_cur_tgt,
  output logic [CNT_W-1:0]      o_ostd_cnt,
  output logic [1:0]            o_state,
  output logic                  o_timeout,
  output logic                  o_underflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MST_OSTDREQ_NUM);

  logic             w_in_rst;
  logic             w_tgt_nz;
  logic             w_tgt_match;
  logic             w_allow;
  logic             w_ar_hs;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SLV_NB:0]  r_cur_tgt;
  logic [SLV_NB:0]  w_cur_tgt_nxt;
  logic             r_underflow;
  logic             w_underflow_nxt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_timeout;

  // Admission: only registered state and the decoded target, never o_arready.
  // Reset inputs gate it so nothing is forwarded while reset is asserted.
  assign w_in_rst    = arst | srst;
  assign w_tgt_nz    = |bus.i_ar_tgt;
  assign w_tgt_match = (bus.i_ar_tgt == r_cur_tgt);
  assign w_allow     = !w_in_rst & w_tgt_nz & (r_cnt < MAX_CNT)
                     & ((r_cnt == '0) | w_tgt_match);

  assign bus.o_arvalid = bus.i_arvalid & w_allow;
  assign bus.i_arready = bus.o_arready & w_allow;
  assign w_ar_hs       = bus.o_arvalid & bus.o_arready;

  // Outstanding counter / owner target / underflow
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_cur_tgt_nxt   = r_cur_tgt;
    w_underflow_nxt = 1'b0;
    unique case ({w_ar_hs, bus.i_rdone})
      2'b10: begin
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_cur_tgt_nxt = bus.i_ar_tgt;
      end
      2'b01: begin
        if (r_cnt == '0) begin
          w_underflow_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      2'b11: begin
        w_cur_tgt_nxt = bus.i_ar_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_cnt       <= '0;
      r_cur_tgt   <= '0;
      r_underflow <= 1'b0;
    end else if (srst) begin
      r_cnt       <= '0;
      r_cur_tgt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_cur_tgt   <= w_cur_tgt_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // FSM
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else if (srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs && (w_cnt_nxt != '0)) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_cnt_nxt == '0)
          w_state_nxt = ST_IDLE;
        else if (bus.i_arvalid && w_tgt_nz && !w_tgt_match)
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_cnt_nxt == '0)
          w_state_nxt = ST_IDLE;
        else if (!bus.i_arvalid)
          w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog
  generate
    if (TIMEOUT_ENABLE) begin : g_wdog
      axicb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_wdog (
        .clk     (aclk),
        .rst     (arst),
        .clr     (srst | bus.i_rdone | (r_cnt == '0)),
        .run     (1'b1),
        .expired (w_timeout)
      );
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign o_cur_tgt   = r_cur_tgt;
  assign o_ostd_cnt  = r_cnt;
  assign o_state     = r_state;
  assign o_timeout   = w_timeout;
  assign o_underflow = r_underflow;

  a_tgt_onehot: assert property (@(posedge aclk) disable iff (arst || srst)
    bus.i_arvalid |-> onehot_valid(ONEHOT_CHK_W'(bus.i_ar_tgt)));

  a_cnt_max: assert property (@(posedge aclk) disable iff (arst)
    r_cnt <= MAX_CNT);

endmodule

// File: tb/tb_axicb_rd_ostd_ctrl.sv
// Directed bench for axicb_rd_ostd_ctrl: a vector table for single-cycle
// behaviour plus hand-written watchdog and reset sequences.
module tb_axicb_rd_ostd_ctrl;

  localparam int unsigned SLV_NB = 4;
  localparam int unsigned OSTD   = 4;
  localparam int unsigned TMO    = 16;
  localparam int unsigned CNT_W  = 3;

  logic              aclk;
  logic              arst;
  logic              srst;
  logic [SLV_NB:0]   cur_tgt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        st;
  logic              tmo;
  logic              uf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  axicb_rd_ostd_ctrl_if #(.SLV_NB(SLV_NB)) bus ();

  axicb_rd_ostd_ctrl #(
    .SLV_NB          (SLV_NB),
    .MST_OSTDREQ_NUM (OSTD),
    .TIMEOUT_ENABLE  (1'b1),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .aclk        (aclk),
    .arst        (arst),
    .srst        (srst),
    .bus         (bus),
    .o_cur_tgt   (cur_tgt),
    .o_ostd_cnt  (cnt),
    .o_state     (st),
    .o_timeout   (tmo),
    .o_underflow (uf)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic       v;
    logic [4:0] tgt;
    logic       ordy;
    logic       rd;
    logic       e_iar;
    logic       e_oarv;
    logic [2:0] e_cnt;
    logic [4:0] e_tgt;
    logic [1:0] e_st;
    logic       e_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [4:0] tgt, input logic ordy,
                              input logic rd, input logic e_iar, input logic e_oarv,
                              input logic [2:0] e_cnt, input logic [4:0] e_tgt,
                              input logic [1:0] e_st, input logic e_uf);
    vec_t r;
    r.v = v; r.tgt = tgt; r.ordy = ordy; r.rd = rd;
    r.e_iar = e_iar; r.e_oarv = e_oarv; r.e_cnt = e_cnt;
    r.e_tgt = e_tgt; r.e_st = e_st; r.e_uf = e_uf;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] t, input logic ordy, input logic rd);
    bus.i_arvalid = v;
    bus.i_ar_tgt  = t;
    bus.o_arready = ordy;
    bus.i_rdone   = rd;
  endtask

  // 3 same-target handshakes then hold an AR to another slave -> DRAIN, cnt=3
  task automatic build_drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk); drive(1'b1, 5'b00001, 1'b1, 1'b0);
    end
    @(negedge aclk); drive(1'b1, 5'b00010, 1'b1, 1'b0);
    repeat (17) @(posedge aclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state with a pending AR that would otherwise be admitted
    arst = 1'b1; srst = 1'b0;
    drive(1'b1, 5'b00001, 1'b1, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_tgt", 32'(cur_tgt), 32'd0);
    check("rst_state", 32'(st), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    check("rst_uf", 32'(uf), 32'd0);
    check("rst_iar", 32'(bus.i_arready), 32'd0);
    check("rst_oarv", 32'(bus.o_arvalid), 32'd0);
    @(negedge aclk);
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    arst = 1'b0;

    //               v  tgt       ordy rd  iar oarv cnt  exp_tgt   st   uf
    // same-target burst, 5th held at cap, released by one completion
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd1, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd2, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd3, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd4, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 0,  0, 0,  3'd4, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 1,  0, 0,  3'd3, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd4, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 1,  0, 0,  3'd3, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 1,  0, 0,  3'd2, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 1,  0, 0,  3'd1, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 1,  0, 0,  3'd0, 5'b00001, 2'd0, 0));
    // underflow pulse, cur_tgt retained
    vecs.push_back(mk(0, 5'b00001, 0, 1,  0, 0,  3'd0, 5'b00001, 2'd0, 1));
    vecs.push_back(mk(0, 5'b00001, 0, 0,  0, 0,  3'd0, 5'b00001, 2'd0, 0));
    // target switch: drain two reads on slave0, then slave2 admitted
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd1, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00001, 1, 0,  1, 1,  3'd2, 5'b00001, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00100, 1, 0,  0, 0,  3'd2, 5'b00001, 2'd2, 0));
    vecs.push_back(mk(1, 5'b00100, 1, 1,  0, 0,  3'd1, 5'b00001, 2'd2, 0));
    vecs.push_back(mk(1, 5'b00100, 1, 1,  0, 0,  3'd0, 5'b00001, 2'd0, 0));
    vecs.push_back(mk(1, 5'b00100, 1, 0,  1, 1,  3'd1, 5'b00100, 2'd1, 0));
    // DRAIN returns to ACTIVE when the blocked AR is withdrawn
    vecs.push_back(mk(1, 5'b00010, 1, 0,  0, 0,  3'd1, 5'b00100, 2'd2, 0));
    vecs.push_back(mk(0, 5'b00010, 1, 0,  0, 0,  3'd1, 5'b00100, 2'd1, 0));
    // simultaneous handshake and completion at cnt=3
    vecs.push_back(mk(1, 5'b00100, 1, 0,  1, 1,  3'd2, 5'b00100, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00100, 1, 0,  1, 1,  3'd3, 5'b00100, 2'd1, 0));
    vecs.push_back(mk(1, 5'b00100, 1, 1,  1, 1,  3'd3, 5'b00100, 2'd1, 0));
    // undecoded target is never forwarded
    vecs.push_back(mk(1, 5'b00000, 1, 0,  0, 0,  3'd3, 5'b00100, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 1,  0, 0,  3'd2, 5'b00100, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 1,  0, 0,  3'd1, 5'b00100, 2'd1, 0));
    vecs.push_back(mk(0, 5'b00000, 0, 1,  0, 0,  3'd0, 5'b00100, 2'd0, 0));
    // misroute (DECERR) target is a normal target
    vecs.push_back(mk(1, 5'b10000, 1, 0,  1, 1,  3'd1, 5'b10000, 2'd1, 0));
    vecs.push_back(mk(0, 5'b10000, 0, 1,  0, 0,  3'd0, 5'b10000, 2'd0, 0));

    foreach (vecs[i]) begin
      @(negedge aclk);
      drive(vecs[i].v, vecs[i].tgt, vecs[i].ordy, vecs[i].rd);
      #1;
      check($sformatf("v%0d_iar", i), 32'(bus.i_arready), 32'(vecs[i].e_iar));
      check($sformatf("v%0d_oarv", i), 32'(bus.o_arvalid), 32'(vecs[i].e_oarv));
      @(posedge aclk);
      #1;
      check($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_tgt", i), 32'(cur_tgt), 32'(vecs[i].e_tgt));
      check($sformatf("v%0d_state", i), 32'(st), 32'(vecs[i].e_st));
      check($sformatf("v%0d_uf", i), 32'(uf), 32'(vecs[i].e_uf));
      check($sformatf("v%0d_tmo", i), 32'(tmo), 32'd0);
    end

    // Watchdog: one read, no completion
    @(negedge aclk); drive(1'b1, 5'b00001, 1'b1, 1'b0);
    @(posedge aclk); #1;
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    check("wd_cnt", 32'(cnt), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge aclk); #1;
      check($sformatf("wd_tmo_c%0d", k), 32'(tmo), (k >= 16) ? 32'd1 : 32'd0);
    end
    @(negedge aclk); drive(1'b0, 5'b00001, 1'b0, 1'b1);
    @(posedge aclk); #1;
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    check("wd_clr_tmo", 32'(tmo), 32'd0);
    check("wd_clr_cnt", 32'(cnt), 32'd0);
    check("wd_clr_state", 32'(st), 32'd0);

    // Asynchronous reset mid-operation
    build_drain();
    check("ar_pre_cnt", 32'(cnt), 32'd3);
    check("ar_pre_state", 32'(st), 32'd2);
    check("ar_pre_tmo", 32'(tmo), 32'd1);
    @(negedge aclk);
    #2 arst = 1'b1;
    #1;
    check("ar_cnt", 32'(cnt), 32'd0);
    check("ar_state", 32'(st), 32'd0);
    check("ar_tmo", 32'(tmo), 32'd0);
    check("ar_iar", 32'(bus.i_arready), 32'd0);
    check("ar_oarv", 32'(bus.o_arvalid), 32'd0);
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    @(negedge aclk); arst = 1'b0;

    // Synchronous reset mid-operation
    build_drain();
    check("sr_pre_cnt", 32'(cnt), 32'd3);
    check("sr_pre_state", 32'(st), 32'd2);
    check("sr_pre_tmo", 32'(tmo), 32'd1);
    @(negedge aclk); srst = 1'b1;
    #1;
    check("sr_iar", 32'(bus.i_arready), 32'd0);
    check("sr_oarv", 32'(bus.o_arvalid), 32'd0);
    check("sr_hold_cnt", 32'(cnt), 32'd3);
    @(posedge aclk); #1;
    check("sr_cnt", 32'(cnt), 32'd0);
    check("sr_state", 32'(st), 32'd0);
    check("sr_tmo", 32'(tmo), 32'd0);
    check("sr_tgt", 32'(cur_tgt), 32'd0);
    check("sr_uf", 32'(uf), 32'd0);
    @(negedge aclk);
    srst = 1'b0;
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    repeat (2) @(posedge aclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
